fifo_read_stream: RTL and testbench

//  Read-side drain for the switch's clock-crossing FIFOs. Pops words through the FIFO's

---
 rtl/switch_pkg.sv | 17 +
 rtl/skid_buf2.sv | 92 +++++++++
 rtl/fifo_read_stream.sv | 86 ++++++++
 tb/tb_fifo_read_stream.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// ---------------------------------------------------------------------------
// switch_pkg
//   Shared types and constants for the switch's FIFO read-side logic.
//   occ_t      : occupancy of the 2-entry skid buffer on the read stream.
//   SKID_DEPTH : number of words the skid buffer can hold.
// ---------------------------------------------------------------------------
package switch_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  localparam int unsigned SKID_DEPTH = 2;

endpackage : switch_pkg

// File: rtl/skid_buf2.sv
// ---------------------------------------------------------------------------
// skid_buf2
//   Two-entry register buffer in strict FIFO order. The head entry is
//   presented on headData straight from a flop.
// Ports
//   clk      in   clock
//   rstn     in   asynchronous active-low reset
//   wrEn     in   write wrData at the tail this edge
//   wrData   in   word to write
//   rdEn     in   remove the head entry this edge
//   clr      in   synchronous clear (wins over wrEn/rdEn)
//   headData out  head entry (registered)
//   occ      out  number of entries held
// ---------------------------------------------------------------------------
module skid_buf2
  import switch_pkg::*;
#(
  parameter int unsigned width = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wrEn,
  input  logic [width-1:0] wrData,
  input  logic             rdEn,
  input  logic             clr,
  output logic [width-1:0] headData,
  output occ_t             occ
);

  logic [width-1:0] head_q, head_d;
  logic [width-1:0] tail_q, tail_d;
  occ_t             occ_q,  occ_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (clr) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (wrEn) begin
            head_d = wrData;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (wrEn && rdEn) begin
            // Head leaves and the new word takes its place directly.
            head_d = wrData;
          end else if (wrEn) begin
            tail_d = wrData;
            occ_d  = OCC_TWO;
          end else if (rdEn) begin
            occ_d  = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // A write without a read is blocked upstream by the read guard.
          if (rdEn) begin
            head_d = tail_q;
            if (wrEn) tail_d = wrData;
            else      occ_d  = OCC_ONE;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  // NOTE: the two data entries are reset as well, because the head drives the
  // stream output and must read as zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= OCC_EMPTY;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign headData = head_q;
  assign occ      = occ_q;

endmodule : skid_buf2

// File: rtl/fifo_read_stream.sv
// ---------------------------------------------------------------------------
// fifo_read_stream
//   Drains a FIFO with one cycle of read latency and re-presents its words as
//   a valid/ready stream at one word per clock. A 2-entry skid buffer absorbs
//   the read latency; the read guard never lets buffered plus in-flight words
//   exceed the buffer depth.
// Ports
//   clk        in   FIFO read clock
//   rstn       in   asynchronous active-low reset
//   fifoEmpty  in   FIFO empty
//   fifoRead   out  pop request (combinational)
//   fifoData   in   popped word, valid the cycle after fifoRead
//   outValid   out  stream valid (registered)
//   outReady   in   downstream ready
//   outData    out  stream word (registered)
//   flush      in   synchronous discard of buffered and in-flight words
//   wordCount  out  words delivered since reset (wraps)
//   busy       out  outValid | word in flight
// ---------------------------------------------------------------------------
module fifo_read_stream
  import switch_pkg::*;
#(
  parameter int unsigned width    = 1,
  parameter int unsigned cntWidth = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                fifoEmpty,
  output logic                fifoRead,
  input  logic [width-1:0]    fifoData,
  output logic                outValid,
  input  logic                outReady,
  output logic [width-1:0]    outData,
  input  logic                flush,
  output logic [cntWidth-1:0] wordCount,
  output logic                busy
);

  logic                in_flight_q, in_flight_d;
  logic [cntWidth-1:0] word_count_q, word_count_d;
  occ_t                occ;
  logic                pop;
  logic                capture;
  logic [2:0]          load;

  always_comb begin
    pop     = outValid & outReady;
    capture = in_flight_q & ~flush;
    // Words already committed to the buffer: held entries plus the one in flight.
    load    = {1'b0, occ} + {2'b00, in_flight_q};
    // Issue a read only if the word will still fit after this cycle's pop.
    // rstn gates the request so the FIFO is never popped while held in reset.
    fifoRead     = rstn & ~fifoEmpty & ~flush &
                   (load < (3'(SKID_DEPTH) + {2'b00, pop}));
    in_flight_d  = fifoRead;
    word_count_d = word_count_q + cntWidth'(pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_flight_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      in_flight_q  <= in_flight_d;
      word_count_q <= word_count_d;
    end
  end

  skid_buf2 #(
    .width (width)
  ) u_skid (
    .clk      (clk),
    .rstn     (rstn),
    .wrEn     (capture),
    .wrData   (fifoData),
    .rdEn     (pop),
    .clr      (flush),
    .headData (outData),
    .occ      (occ)
  );

  assign outValid  = (occ != OCC_EMPTY);
  assign busy      = outValid | in_flight_q;
  assign wordCount = word_count_q;

endmodule : fifo_read_stream

// File: tb/tb_fifo_read_stream.sv
// ---------------------------------------------------------------------------
// tb_fifo_read_stream
//   Self-checking bench. A FIFO is emulated with a queue; a reference model
//   tracks outstanding words (read but not yet delivered) with the cycle each
//   was read, and derives valid, data, read request, busy and count from that.
//   A second instance with a 4-bit counter exercises counter wrap.
// ---------------------------------------------------------------------------
module tb_fifo_read_stream;

  localparam int W = 8;

  logic         clk       = 1'b0;
  logic         rstn      = 1'b0;
  logic         fifoEmpty = 1'b1;
  logic         outReady  = 1'b0;
  logic         flush     = 1'b0;
  logic [W-1:0] fifoData  = '0;

  logic         fifoRead, outValid, busy;
  logic [W-1:0] outData;
  logic [15:0]  wordCount;

  logic         fifoRead_n, outValid_n, busy_n;
  logic [W-1:0] outData_n;
  logic [3:0]   wordCount_n;

  always #5 clk = ~clk;

  fifo_read_stream #(.width(W), .cntWidth(16)) dut (
    .clk(clk), .rstn(rstn), .fifoEmpty(fifoEmpty), .fifoRead(fifoRead),
    .fifoData(fifoData), .outValid(outValid), .outReady(outReady),
    .outData(outData), .flush(flush), .wordCount(wordCount), .busy(busy)
  );

  fifo_read_stream #(.width(W), .cntWidth(4)) dut_n (
    .clk(clk), .rstn(rstn), .fifoEmpty(fifoEmpty), .fifoRead(fifoRead_n),
    .fifoData(fifoData), .outValid(outValid_n), .outReady(outReady),
    .outData(outData_n), .flush(flush), .wordCount(wordCount_n), .busy(busy_n)
  );

  typedef struct {
    logic [W-1:0] data;
    int           rd_cyc;
  } ent_t;

  logic [W-1:0] fifo_q[$];
  ent_t         exp_q[$];
  int           cyc       = 0;
  int           exp_cnt   = 0;
  int           rd_pulses = 0;
  int           n_tests   = 0;
  int           n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model,
  // then present the FIFO's read data just after the rising edge.
  task automatic cycle(input logic rdy, input logic fl, input logic gap);
    logic         exp_valid, exp_pop, exp_rd;
    logic [W-1:0] nd;
    outReady  = rdy;
    flush     = fl;
    fifoEmpty = (fifo_q.size() == 0) || gap;
    @(negedge clk);
    // A word becomes visible two cycles after its read and stays until popped.
    exp_valid = (exp_q.size() > 0) && (exp_q[0].rd_cyc + 2 <= cyc);
    exp_pop   = exp_valid && rdy;
    exp_rd    = !fifoEmpty && !fl && ((exp_q.size() - int'(exp_pop)) < 2);
    check("outValid", {31'd0, outValid}, {31'd0, exp_valid});
    if (exp_valid) check("outData", {24'd0, outData}, {24'd0, exp_q[0].data});
    check("fifoRead", {31'd0, fifoRead}, {31'd0, exp_rd});
    if (fifoEmpty) check("noReadWhenEmpty", {31'd0, fifoRead}, 32'd0);
    check("busy", {31'd0, busy}, {31'd0, exp_q.size() > 0});
    check("wordCount", {16'd0, wordCount}, 32'(exp_cnt % 65536));
    check("wordCountNarrow", {28'd0, wordCount_n}, 32'(exp_cnt % 16));
    check("narrowAgree", {21'd0, outValid_n, outData_n, fifoRead_n, busy_n},
                         {21'd0, outValid,   outData,   fifoRead,   busy});
    check("holdLimit", 32'(exp_q.size() - int'(exp_pop) + int'(exp_rd)), 32'(exp_q.size() - int'(exp_pop) + int'(exp_rd) > 2 ? 2 : exp_q.size() - int'(exp_pop) + int'(exp_rd)));
    if (exp_pop) begin
      void'(exp_q.pop_front());
      exp_cnt++;
    end
    if (fl) exp_q.delete();
    nd = W'($urandom);
    if (fifoRead === 1'b1 && fifo_q.size() > 0) begin
      nd = fifo_q.pop_front();
      exp_q.push_back('{data: nd, rd_cyc: cyc});
      rd_pulses++;
    end
    cyc++;
    @(posedge clk);
    #1;
    fifoData = nd;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 300) begin
      cycle(1'b1, 1'b0, 1'b0);
      n++;
    end
    check(tag, 32'(fifo_q.size() + exp_q.size()), 32'd0);
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(W'($urandom));
  endtask

  int cnt_before;

  initial begin
    // Reset state; fifoEmpty low shows the read request is held off in reset.
    fifoEmpty = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outValid",  {31'd0, outValid}, 32'd0);
    check("rst_outData",   {24'd0, outData},  32'd0);
    check("rst_wordCount", {16'd0, wordCount}, 32'd0);
    check("rst_busy",      {31'd0, busy},     32'd0);
    check("rst_fifoRead",  {31'd0, fifoRead}, 32'd0);
    rstn = 1'b1;

    // Streaming: 0x1..0x8 preloaded, ready held high.
    for (int i = 1; i <= 8; i++) fifo_q.push_back(W'(i));
    repeat (12) cycle(1'b1, 1'b0, 1'b0);
    check("stream_count", {16'd0, wordCount}, 32'd8);

    // Backpressure: only two reads, head 0x1 held stable, then full release.
    for (int i = 1; i <= 8; i++) fifo_q.push_back(W'(i));
    rd_pulses = 0;
    repeat (6) cycle(1'b0, 1'b0, 1'b0);
    check("bp_reads", 32'(rd_pulses), 32'd2);
    check("bp_head",  {24'd0, outData}, 32'd1);
    check("bp_valid", {31'd0, outValid}, 32'd1);
    drain("bp_drain");
    check("bp_count", {16'd0, wordCount}, 32'd16);

    // Asynchronous reset mid-stream with two words buffered.
    load_random(8);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("midrst_outValid",  {31'd0, outValid}, 32'd0);
    check("midrst_wordCount", {16'd0, wordCount}, 32'd0);
    check("midrst_fifoRead",  {31'd0, fifoRead}, 32'd0);
    check("midrst_busy",      {31'd0, busy},     32'd0);
    exp_q.delete();
    fifo_q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Counter wrap: 17 words delivered since reset.
    load_random(17);
    drain("wrap_drain");
    check("wrap_narrow", {28'd0, wordCount_n}, 32'd1);
    check("wrap_wide",   {16'd0, wordCount},   32'd17);

    // Flush with the buffer full and nothing in flight.
    load_random(8);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    cnt_before = exp_cnt;
    cycle(1'b0, 1'b1, 1'b0);
    check("flush_full_valid", {31'd0, outValid}, 32'd0);
    check("flush_full_count", {16'd0, wordCount}, 32'(cnt_before));
    drain("flush_full_drain");

    // Flush while streaming: one buffered, one in flight, pop in same cycle.
    load_random(8);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    cnt_before = exp_cnt;
    cycle(1'b1, 1'b1, 1'b0);
    check("flush_pop_valid", {31'd0, outValid}, 32'd0);
    check("flush_pop_count", {16'd0, wordCount}, 32'(cnt_before + 1));
    drain("flush_pop_drain");

    // Alternating ready with randomly gapped FIFO availability.
    load_random(40);
    for (int i = 0; i < 120; i++)
      cycle(logic'(i % 2 == 0), 1'b0, logic'($urandom_range(0, 3) == 0));
    drain("toggle_drain");

    // Random ready, gaps and occasional flushes.
    load_random(60);
    for (int i = 0; i < 150; i++)
      cycle(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 15) == 0),
            logic'($urandom_range(0, 3) == 0));
    drain("random_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fifo_read_stream
